io_timer_responder: RTL and testbench

Memory-mapped timer/output-compare peripheral on the CPU data bus. Responds to pipelined-core loads and stores in its own address window. Drives the `oc` PWM/compare pin and exposes the `pin_data` input word: synchronized, with edge-triggered count capture. Sits beside the data RAM, selected by address decode; read data is combinational so the core's memory stage sees it in the same cycle.

---
 rtl/io_timer_responder_pkg.sv | 26 ++
 rtl/io_timer_responder_pin_synchronizer.sv | 31 +++
 rtl/io_timer_responder.sv | 186 ++++++++++++++++++
 tb/tb_io_timer_responder.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_responder_pkg.sv
// Shared constants for the io_timer_responder peripheral: register indices,
// CTRL/STATUS bit positions and the address window size.
package io_timer_responder_pkg;

  // Register indices, taken from address[4:2].
  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PERIOD   = 3'd1;
  localparam logic [2:0] REG_COMPARE  = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_PIN      = 3'd4;
  localparam logic [2:0] REG_CAPTURE  = 3'd5;
  localparam logic [2:0] REG_STATUS   = 3'd6;
  localparam logic [2:0] REG_PRESCALE = 3'd7;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN  = 0;
  localparam int unsigned CTRL_POL = 1;

  // STATUS bit positions.
  localparam int unsigned STAT_WRAP = 0;
  localparam int unsigned STAT_CAPT = 1;

  // Byte size of the register window.
  localparam int unsigned WINDOW_BYTES = 32;

endpackage

// File: rtl/io_timer_responder_pin_synchronizer.sv
// pin_synchronizer: two-flop synchronizer for a vector of asynchronous inputs.
// Ports:
//   clk     - destination clock
//   n_reset - asynchronous active-low reset, clears both stages
//   d       - asynchronous input vector
//   q       - synchronized output vector (second stage)
module pin_synchronizer #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d;
      stage2_q <= stage1_q;
    end
  end

  assign q = stage2_q;

endmodule

// File: rtl/io_timer_responder.sv
// io_timer_responder: memory-mapped timer / output-compare peripheral with a
// synchronized input word and edge-triggered count capture.
// Ports:
//   clk, n_reset - clock and asynchronous active-low reset
//   address      - byte address; window selected by address[31:5]
//   data_in      - store data
//   mem_read     - load strobe (data_out is combinational)
//   mem_write    - store strobe (takes effect at posedge clk)
//   data_out     - read data, 0 when not reading this window
//   pin_data     - asynchronous external input word
//   oc           - registered output-compare pin
module io_timer_responder
  import io_timer_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] data_out,
  input  logic [31:0] pin_data,
  output logic        oc
);

  logic                  en_q, en_d, pol_q, pol_d;
  logic [31:0]           period_q, period_d, compare_q, compare_d;
  logic [31:0]           period_act_q, period_act_d, compare_act_q, compare_act_d;
  logic [31:0]           count_q, count_d, capture_q, capture_d;
  logic                  wrap_q, wrap_d, capt_q, capt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d, presc_cnt_q, presc_cnt_d;
  logic [31:0]           pin_s, pin_q;
  logic                  oc_q, oc_d;

  logic       sel;
  logic [2:0] idx;
  logic       wr_en;
  logic       tick;
  logic       wrap_evt;
  logic       pin_change;
  logic       unused_addr;

  assign sel         = (address[31:5] == BASE_ADDR[31:5]);
  assign idx         = address[4:2];
  assign wr_en       = mem_write & sel;
  assign unused_addr = ^address[1:0];

  assign tick       = en_q && (presc_cnt_q == prescale_q);
  assign wrap_evt   = tick && (count_q == period_act_q);
  assign pin_change = (pin_s != pin_q);

  pin_synchronizer #(
    .Width(32)
  ) u_pin_sync (
    .clk    (clk),
    .n_reset(n_reset),
    .d      (pin_data),
    .q      (pin_s)
  );

  always_comb begin
    en_d          = en_q;
    pol_d         = pol_q;
    period_d      = period_q;
    compare_d     = compare_q;
    period_act_d  = period_act_q;
    compare_act_d = compare_act_q;
    count_d       = count_q;
    capture_d     = capture_q;
    prescale_d    = prescale_q;
    presc_cnt_d   = presc_cnt_q;

    if (wr_en) begin
      unique case (idx)
        REG_CTRL: begin
          en_d  = data_in[CTRL_EN];
          pol_d = data_in[CTRL_POL];
        end
        REG_PERIOD:   period_d   = data_in;
        REG_COMPARE:  compare_d  = data_in;
        REG_PRESCALE: prescale_d = data_in[PRESCALE_W-1:0];
        default: ;
      endcase
    end

    // Prescaler zeroes while disabled and as soon as a CTRL write clears EN.
    if (!en_q || (wr_en && (idx == REG_CTRL) && !data_in[CTRL_EN])) begin
      presc_cnt_d = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
    end else begin
      presc_cnt_d = presc_cnt_q + 1'b1;
    end

    // Active copies track the shadows while stopped, else reload at a wrap.
    if (!en_q) begin
      period_act_d  = period_d;
      compare_act_d = compare_d;
    end else if (wrap_evt) begin
      period_act_d  = period_q;
      compare_act_d = compare_q;
    end

    // A COUNT store overrides the tick update in the same cycle.
    if (wr_en && (idx == REG_COUNT)) begin
      count_d = data_in;
    end else if (tick) begin
      count_d = wrap_evt ? 32'd0 : count_q + 32'd1;
    end

    if (pin_change) begin
      capture_d = count_q;
    end

    // Sticky flags: a set in the same cycle as a write-1-to-clear wins.
    wrap_d = wrap_evt |
             (wrap_q & ~(wr_en && (idx == REG_STATUS) && data_in[STAT_WRAP]));
    capt_d = pin_change |
             (capt_q & ~(wr_en && (idx == REG_STATUS) && data_in[STAT_CAPT]));

    oc_d = en_q ? ((count_q < compare_act_q) ^ pol_q) : pol_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      en_q          <= 1'b0;
      pol_q         <= 1'b0;
      period_q      <= '0;
      compare_q     <= '0;
      period_act_q  <= '0;
      compare_act_q <= '0;
      count_q       <= '0;
      capture_q     <= '0;
      wrap_q        <= 1'b0;
      capt_q        <= 1'b0;
      prescale_q    <= '0;
      presc_cnt_q   <= '0;
      pin_q         <= '0;
      oc_q          <= 1'b0;
    end else begin
      en_q          <= en_d;
      pol_q         <= pol_d;
      period_q      <= period_d;
      compare_q     <= compare_d;
      period_act_q  <= period_act_d;
      compare_act_q <= compare_act_d;
      count_q       <= count_d;
      capture_q     <= capture_d;
      wrap_q        <= wrap_d;
      capt_q        <= capt_d;
      prescale_q    <= prescale_d;
      presc_cnt_q   <= presc_cnt_d;
      pin_q         <= pin_s;
      oc_q          <= oc_d;
    end
  end

  assign oc = oc_q;

  always_comb begin
    data_out = '0;
    if (mem_read && sel) begin
      unique case (idx)
        REG_CTRL: begin
          data_out[CTRL_EN]  = en_q;
          data_out[CTRL_POL] = pol_q;
        end
        REG_PERIOD:   data_out = period_q;
        REG_COMPARE:  data_out = compare_q;
        REG_COUNT:    data_out = count_q;
        REG_PIN:      data_out = pin_s;
        REG_CAPTURE:  data_out = capture_q;
        REG_STATUS: begin
          data_out[STAT_WRAP] = wrap_q;
          data_out[STAT_CAPT] = capt_q;
        end
        REG_PRESCALE: data_out[PRESCALE_W-1:0] = prescale_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer_responder.sv
// Scoreboard bench for io_timer_responder: the driver pushes expected read data
// and expected oc levels from a behavioural model; a monitor pops and compares.
module tb_io_timer_responder;

  localparam logic [31:0] Base = 32'h0000_0100;

  logic        clk;
  logic        n_reset;
  logic [31:0] address;
  logic [31:0] data_in;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] data_out;
  logic [31:0] pin_data;
  logic        oc;

  io_timer_responder #(
    .BASE_ADDR (Base),
    .PRESCALE_W(16)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .address  (address),
    .data_in  (data_in),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .data_out (data_out),
    .pin_data (pin_data),
    .oc       (oc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] rd_exp[$];
  logic        oc_exp[$];

  // Behavioural model state.
  bit          m_en, m_pol, m_wrap, m_capt, m_oc;
  logic [31:0] m_period, m_compare, m_pact, m_cact, m_count, m_capture;
  logic [31:0] m_presc, m_pcnt;
  logic [31:0] m_sync1, m_pin, m_pin_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ra(input int idx);
    return Base + 32'(idx * 4);
  endfunction

  task automatic model_reset();
    m_en = 0; m_pol = 0; m_wrap = 0; m_capt = 0; m_oc = 0;
    m_period = 0; m_compare = 0; m_pact = 0; m_cact = 0; m_count = 0; m_capture = 0;
    m_presc = 0; m_pcnt = 0; m_sync1 = 0; m_pin = 0; m_pin_prev = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:5] != Base[31:5]) return 32'd0;
    case (a[4:2])
      3'd0: return {30'd0, m_pol, m_en};
      3'd1: return m_period;
      3'd2: return m_compare;
      3'd3: return m_count;
      3'd4: return m_pin;
      3'd5: return m_capture;
      3'd6: return {30'd0, m_capt, m_wrap};
      default: return m_presc;
    endcase
  endfunction

  // One clock edge of the peripheral, expressed from the register-level rules.
  task automatic model_step();
    bit          hit, tick, wrapped, clr_en;
    int          idx;
    logic [31:0] d;
    logic [31:0] old_period, old_compare, old_count;
    hit = mem_write && (address[31:5] == Base[31:5]);
    idx = int'(address[4:2]);
    d = data_in;
    tick = m_en && (m_pcnt == m_presc);
    wrapped = tick && (m_count == m_pact);
    clr_en = hit && idx == 0 && !d[0];
    old_period = m_period;
    old_compare = m_compare;
    old_count = m_count;

    m_oc = m_en ? ((m_count < m_cact) ^ m_pol) : m_pol;
    if (m_pin != m_pin_prev) begin
      m_capture = old_count;
      m_capt = 1;
    end else if (hit && idx == 6 && d[1]) m_capt = 0;
    if (wrapped) m_wrap = 1;
    else if (hit && idx == 6 && d[0]) m_wrap = 0;

    if (hit && idx == 1) m_period = d;
    if (hit && idx == 2) m_compare = d;
    if (hit && idx == 7) m_presc = {16'd0, d[15:0]};

    if (hit && idx == 3) m_count = d;
    else if (wrapped) m_count = 0;
    else if (tick) m_count = old_count + 1;

    if (!m_en) begin
      m_pact = m_period;
      m_cact = m_compare;
    end else if (wrapped) begin
      m_pact = old_period;
      m_cact = old_compare;
    end

    if (!m_en || clr_en || tick) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;

    if (hit && idx == 0) begin
      m_en = d[0];
      m_pol = d[1];
    end

    m_pin_prev = m_pin;
    m_pin = m_sync1;
    m_sync1 = pin_data;
  endtask

  task automatic cycle(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    address = a;
    mem_read = rd;
    mem_write = wr;
    data_in = wd;
    oc_exp.push_back(m_oc);
    if (rd) rd_exp.push_back(model_read(a));
    @(posedge clk);
    model_step();
    #1;
    mem_read = 0;
    mem_write = 0;
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] wd);
    cycle(0, 1, ra(idx), wd);
  endtask

  task automatic rd_reg(input int idx);
    cycle(1, 0, ra(idx), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 32'd0, 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  initial begin
    logic [31:0] e;
    logic        eo;
    forever begin
      @(negedge clk);
      if (oc_exp.size() != 0) begin
        eo = oc_exp.pop_front();
        check("oc", {31'd0, oc}, {31'd0, eo});
      end
      if (mem_read) begin
        if (rd_exp.size() == 0) begin
          check("read_queue_empty", 32'd1, 32'd0);
        end else begin
          e = rd_exp.pop_front();
          check($sformatf("read_idx%0d_addr%0h", address[4:2], address), data_out, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hi;
    int guard;
    logic [31:0] wd;
    int idx;
    address = 0; data_in = 0; mem_read = 0; mem_write = 0; pin_data = 0;
    n_reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("oc_in_reset", {31'd0, oc}, 32'd0);
    n_reset = 1;

    // Reset state of every index.
    for (int i = 0; i < 8; i++) rd_reg(i);

    // Basic PWM: 3 high cycles in every 10.
    wr_reg(7, 0);
    wr_reg(1, 9);
    wr_reg(2, 3);
    wr_reg(0, 1);
    idle(5);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      hi += int'(oc);
    end
    check("pwm_high_cycles_per_20", 32'(hi), 32'd6);
    rd_reg(6);
    wr_reg(6, 1);
    rd_reg(6);

    // New COMPARE waits for the next wrap.
    wr_reg(2, 7);
    rd_reg(2);
    idle(25);

    // Pin path and capture.
    pin_data = 50;
    idle(4);
    wr_reg(6, 2);
    rd_reg(6);
    pin_data = 250;
    for (int i = 0; i < 4; i++) rd_reg(4);
    rd_reg(6);
    rd_reg(5);

    // COUNT store on a tick cycle wins over the increment.
    wr_reg(3, 5);
    rd_reg(3);
    check("count_write_wins", m_count, 32'd6);

    // STATUS clear coinciding with a wrap leaves WRAP set.
    guard = 0;
    while (!(m_en && m_pcnt == m_presc && m_count == m_pact) && guard < 100) begin
      idle(1);
      guard++;
    end
    check("wrap_search_bound", 32'(guard < 100), 32'd1);
    wr_reg(6, 1);
    rd_reg(6);
    check("wrap_set_wins", {31'd0, m_wrap}, 32'd1);

    // Outside the window: reads return 0 and stores change nothing.
    for (int i = 0; i < 8; i++) cycle(1, 0, Base + 32'd32 + 32'(i * 4), 32'd0);
    for (int i = 0; i < 8; i++) cycle(0, 1, Base + 32'd32 + 32'(i * 4), 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) rd_reg(i);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      idx = int'($urandom_range(0, 7));
      case (idx)
        0: wd = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 1) * 2 + 1);
        1, 2, 3: wd = 32'($urandom_range(0, 12));
        6: wd = 32'($urandom_range(0, 3));
        7: wd = 32'($urandom_range(0, 3));
        default: wd = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) pin_data = $urandom;
      if ($urandom_range(0, 15) == 0)
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), Base + 32'd64 + 32'(idx * 4), wd);
      else
        cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), ra(idx), wd);
    end

    // Asynchronous reset in the middle of a running period.
    wr_reg(7, 1);
    wr_reg(1, 4);
    wr_reg(2, 5);
    wr_reg(0, 1);
    idle(6);
    #2;
    n_reset = 0;
    #1;
    check("oc_async_reset", {31'd0, oc}, 32'd0);
    model_reset();
    pin_data = 0;
    @(posedge clk);
    #1;
    n_reset = 1;
    for (int i = 0; i < 8; i++) rd_reg(i);

    @(negedge clk);
    #1;
    check("read_queue_drained", 32'(rd_exp.size()), 32'd0);
    check("oc_queue_drained", 32'(oc_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
